// File: rtl/mem_dump.sv
// Synthesizable memory dump: takes over the CPU-style memory port and streams an
// inclusive, wrapping address range out on a valid/ready interface with a running checksum.
module mem_dump #(
    parameter int addr_width = 8,
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [addr_width-1:0] first_addr,
    input  logic [addr_width-1:0] last_addr,
    output logic                  write,
    output logic [addr_width-1:0] addr,
    output logic [data_width-1:0] wdata,
    input  logic [data_width-1:0] rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] out_data,
    output logic [addr_width-1:0] out_addr,
    output logic                  busy,
    output logic                  done,
    output logic [data_width-1:0] checksum
);

    typedef enum logic [1:0] {IDLE, ADDR, READ, SEND} state_t;

    state_t                state;
    logic [addr_width-1:0] last_q;

    // The block only ever reads, so the write side is tied off.
    assign write = 1'b0;
    assign wdata = '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            last_q    <= '0;
            addr      <= '0;
            out_data  <= '0;
            out_addr  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            checksum  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr     <= first_addr;
                        last_q   <= last_addr;
                        checksum <= '0;
                        busy     <= 1'b1;
                        state    <= ADDR;
                    end
                end
                // addr is held over ADDR and READ so registered memories have settled.
                ADDR: state <= READ;
                READ: begin
                    out_data  <= rdata;
                    out_addr  <= addr;
                    checksum  <= checksum + rdata;
                    out_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (addr == last_q) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            addr  <= addr + 1'b1;
                            state <= ADDR;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_dump.md
# mem_dump

Bus-reader counterpart to the memory write path. On a start pulse it takes over the CPU-style memory port (write, addr, wdata, rdata) and reads an inclusive address range. Each byte goes out on a valid/ready stream together with its address, and a running 8-bit-style checksum is kept. It sits beside `memory` in place of the CPU (external mux, selected by `busy`) and replaces the bench-only dump of memory contents with a synthesizable one.

## Interface
- addr_width, 8, memory address width; also the width of range and address outputs
- data_width, 8, memory word width; also the width of the stream data and checksum

- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-low; sampled on rising clk only
- start  input  1  one-cycle request; honoured only in IDLE
- first_addr  input  addr_width  first address read; sampled on the accepted start edge
- last_addr  input  addr_width  last address read, inclusive; sampled on the accepted start edge
- write  output  1  memory write strobe; constant 0
- addr  output  addr_width  memory address
- wdata  output  data_width  memory write data; constant 0
- rdata  input  data_width  memory read data
- out_valid  output  1  stream byte available
- out_ready  input  1  consumer accepts the byte when out_valid is 1
- out_data  output  data_width  byte read
- out_addr  output  addr_width  address of out_data
- busy  output  1  high from the accepted start until completion
- done  output  1  one-cycle pulse on completion
- checksum  output  data_width  sum of all streamed bytes mod 2^data_width; final when done=1

## Operation
- States: IDLE, ADDR, READ, SEND.
- **IDLE**
  - On start=1: capture first_addr and last_addr, set addr<=first_addr, checksum<=0, busy<=1, go to ADDR.
  - start in any other state is ignored.
- **ADDR:** addr is held; one cycle; go to READ.
- **READ:** addr is held.
  - At the end of the cycle: out_data<=rdata, out_addr<=addr, checksum<=checksum+rdata (truncated), out_valid<=1.
  - Go to SEND.
  - Holding addr across two edges tolerates both combinational and 1-cycle registered memory reads.
- **SEND:** out_valid, out_data and out_addr are held stable until the handshake (out_valid & out_ready at a rising edge).
  - On handshake with addr≠last: out_valid<=0, addr<=addr+1 (mod 2^addr_width), go to ADDR.
  - On handshake with addr==last: out_valid<=0, busy<=0, done<=1, go to IDLE.
- **Address range**
  - The range wraps: when last_addr<first_addr, reading runs through 2^addr_width−1, then continues from 0.
  - Byte count = ((last_addr−first_addr) mod 2^addr_width)+1.
  - first_addr==last_addr reads exactly 1 byte. first_addr=last_addr+1 reads the full 2^addr_width bytes.
- write and wdata are always 0, so the block can never corrupt memory.

## Timing
- **Reset values** (on the first rising edge with rst=0):
  - state IDLE
  - addr=0, out_data=0, out_addr=0, checksum=0
  - out_valid=0, busy=0, done=0
  - write=0, wdata=0
- **Reset mid-operation:** takes effect on the next edge regardless of state. A pending out_valid drops without handshake, and no done pulse is produced.
- **Latency**
  - Start accepted at edge E: busy=1 and addr=first_addr after E.
  - out_valid=1 after E+2.
  - After each handshake edge H, the next out_valid=1 after H+2.
  - Minimum 3 cycles per byte; out_ready tied high gives N bytes in 3N cycles.
  - done=1 for exactly the cycle after the final handshake edge. busy is 0 in that same cycle.
  - A new start is accepted in the done cycle.
- **Stream:** out_valid is never withdrawn before handshake.
- **checksum:** updates at the READ edge; stable from the final READ through done and afterwards until the next accepted start.
- start coincident with rst=0: reset wins.

## Test plan
- **Single byte:** mem[0x10]=0xA5; start with first=last=0x10; out_ready=1.
  - One transfer (out_addr=0x10, out_data=0xA5).
  - out_valid rises 3 edges after start.
  - done one cycle after the handshake; checksum=0xA5.
- **Range with backpressure:** mem[0x20..0x23]=01,02,03,04; first=0x20, last=0x23.
  - out_ready low for 5 cycles on the second byte: out_data stays 0x02 throughout.
  - Exactly 4 transfers in order; checksum=0x0A.
  - write stays 0 throughout.
- **Wrap-around:** first=0xFE, last=0x01; mem[FE,FF,00,01]=0x80,0x90,0x10,0x20.
  - out_addr sequence FE, FF, 00, 01.
  - checksum=0x40 (0x140 truncated).
- **Full memory:** first=0x00, last=0xFF, out_ready=1, memory loaded mem[i]=i.
  - 256 transfers in 768 cycles.
  - checksum=0x80.
  - Resulting dump matches the memory image.
- **start while busy:** pulse start with a different range mid-dump; the dump is unaffected.
- **Reset mid-SEND:** rst=0 for one edge.
  - All outputs return to reset values next edge; no done.
  - A subsequent start performs a clean full run.
